// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan-based debounce.
// One row is driven low for SCAN_DIV cycles, and the synchronised columns are
// sampled on the last dwell cycle of that row. The lowest key code seen
// during a full scan is the candidate. A press or release is accepted only
// after DEBOUNCE_CNT consecutive agreeing scans.
module keypad_scanner #(
  parameter int SCAN_DIV     = 12000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  logic [3:0]    col_s1_q, col_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    row_n_q, row_n_d;
  logic          acc_valid_q, acc_valid_d;
  logic [3:0]    acc_code_q, acc_code_d;
  state_t        state_q, state_d;
  logic [3:0]    stored_q, stored_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_held_q, key_held_d;

  logic          row_last, scan_end;
  logic [3:0]    col_hit;
  logic [1:0]    low_col;
  logic          samp_valid;
  logic [3:0]    samp_code;
  logic          cand_valid;
  logic [3:0]    cand_code;
  logic [CW-1:0] cnt_inc;
  logic          cnt_reach;

  // Row sequencing, scan accumulation, candidate selection and debounce next-state.
  always_comb begin
    row_last = (dwell_q == DWELL_LAST);
    scan_end = row_last && (row_q == 2'd3);

    // Lowest-numbered closed column on the driven row.
    col_hit = ~col_s2_q;
    low_col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (col_hit[c]) low_col = 2'(c);
    end
    samp_valid = row_last && (col_hit != 4'd0);
    samp_code  = {row_q, low_col};

    // Rows are visited in ascending order, so the first hit in a scan is the lowest code.
    cand_valid = acc_valid_q || samp_valid;
    cand_code  = acc_valid_q ? acc_code_q : samp_code;

    dwell_d = dwell_q + 1'b1;
    row_d   = row_q;
    if (row_last) begin
      dwell_d = '0;
      row_d   = row_q + 2'd1;
    end
    row_n_d = ~(4'b0001 << row_d);

    acc_valid_d = acc_valid_q;
    acc_code_d  = acc_code_q;
    if (scan_end) begin
      acc_valid_d = 1'b0;
      acc_code_d  = 4'd0;
    end else if (!acc_valid_q && samp_valid) begin
      acc_valid_d = 1'b1;
      acc_code_d  = samp_code;
    end

    cnt_inc   = (cnt_q < CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
    cnt_reach = (int'(cnt_q) + 1) >= DEBOUNCE_CNT;

    state_d     = state_q;
    stored_d    = stored_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;

    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (cand_valid) begin
            stored_d = cand_code;
            cnt_d    = CNT_ONE;
            if (DEBOUNCE_CNT == 1) begin
              state_d     = HELD;
              key_valid_d = 1'b1;
              key_code_d  = cand_code;
              key_held_d  = 1'b1;
            end else begin
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (!cand_valid) begin
            state_d = IDLE;
          end else if (cand_code == stored_q) begin
            cnt_d = cnt_inc;
            if (cnt_reach) begin
              state_d     = HELD;
              key_valid_d = 1'b1;
              key_code_d  = stored_q;
              key_held_d  = 1'b1;
            end
          end else begin
            // A different key restarts confirmation for the new key.
            stored_d = cand_code;
            cnt_d    = CNT_ONE;
            if (DEBOUNCE_CNT == 1) begin
              state_d     = HELD;
              key_valid_d = 1'b1;
              key_code_d  = cand_code;
              key_held_d  = 1'b1;
            end
          end
        end
        HELD: begin
          if (!cand_valid || (cand_code != stored_q)) begin
            cnt_d = CNT_ONE;
            if (DEBOUNCE_CNT == 1) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        default: begin // RELEASE
          if (cand_valid && (cand_code == stored_q)) begin
            // Bounce during release: back to held without a new pulse.
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_reach) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      dwell_q     <= '0;
      row_q       <= 2'd0;
      row_n_q     <= 4'b1110;
      acc_valid_q <= 1'b0;
      acc_code_q  <= 4'd0;
      state_q     <= IDLE;
      stored_q    <= 4'd0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_held_q  <= 1'b0;
    end else begin
      col_s1_q    <= col_n;
      col_s2_q    <= col_s1_q;
      dwell_q     <= dwell_d;
      row_q       <= row_d;
      row_n_q     <= row_n_d;
      acc_valid_q <= acc_valid_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      stored_q    <= stored_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row_n     = row_n_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule
